wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback path and an auxiliary late-result source, such as a multi-cycle multiplier or a delayed data-memory return. It sits between the WB stage outputs and the register file, and feeds a freeze request to the hazard unit. Pipeline writes always win. A starved auxiliary request forces a one-slot pipeline bubble after a bounded wait. A younger pipeline write to the same register supersedes a pending auxiliary write.

## Interface
- MAX_WAIT, default 3: consecutive blocked auxiliary cycles tolerated before freeze is requested. Legal range 1..15.
- clk  in  1  clock. One clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- pipe_wb_en  in  1  WB stage write enable.
- pipe_wb_dest  in  4  WB destination register.
- pipe_wb_value  in  32  WB write value.
- aux_valid  in  1  auxiliary write request.
- aux_dest  in  4  auxiliary destination register.
- aux_value  in  32  auxiliary write value.
- aux_ready  out  1  auxiliary request consumed this cycle (written or squashed).
- rf_wr_en  out  1  register-file write enable.
- rf_wr_dest  out  4  register-file write address.
- rf_wr_value  out  32  register-file write data.
- freeze  out  1  registered request to the hazard unit: hold upstream stages and inject a WB bubble.
- aux_squashed  out  1  pulses with aux_ready when the auxiliary write is dropped by a superseding pipeline write.

## Operation
- Write-port grant (combinational, same cycle):
  - pipe_wb_en=1: rf_wr_* = pipe_wb_*.
  - pipe_wb_en=0 and aux_valid=1: rf_wr_* = aux_*.
  - Otherwise: rf_wr_en=0, rf_wr_dest=0, rf_wr_value=0.
- aux_ready = aux_valid && (!pipe_wb_en || pipe_wb_dest==aux_dest).
- Squash: aux_squashed = aux_valid && pipe_wb_en && pipe_wb_dest==aux_dest.
  - The pipeline value is written.
  - The auxiliary value is discarded; the request is still consumed.
- Auxiliary source rule: while aux_valid && !aux_ready, aux_dest and aux_value are held stable. The bench checks this.
- wait_cnt (4 bits, saturating at MAX_WAIT):
  - Increments each cycle aux_valid && !aux_ready.
  - Clears on any cycle with aux_ready=1 or aux_valid=0.
- FSM states:
  - IDLE: no blocked auxiliary request.
  - WAIT: auxiliary request blocked.
  - FREEZE: freeze=1.
- FSM transitions:
  - IDLE -> WAIT: aux_valid && !aux_ready.
  - WAIT -> IDLE: aux_ready=1 or aux_valid=0.
  - WAIT -> FREEZE: blocked this cycle and wait_cnt+1 == MAX_WAIT.
  - FREEZE -> IDLE: aux_ready=1 or aux_valid=0.
  - Any other case: stay in the current state.
- freeze is 1 exactly while the state is FREEZE.
- Reset: next state IDLE, wait_cnt=0, freeze=0.
- While rst=1, rf_wr_en, aux_ready and aux_squashed are forced to 0.

## Timing
- rf_wr_* and aux_ready: zero latency, combinational from the current inputs.
- freeze: registered; asserted the cycle after the MAX_WAIT-th consecutive blocked cycle.
- Hazard-unit contract: with freeze high in cycle t, pipe_wb_en=0 in cycle t+1. The auxiliary write completes in t+1 at the latest, and freeze falls in t+2.
- A pipeline write arriving in the first freeze cycle (already in flight) still wins. The state remains FREEZE.
- aux_valid dropping while in WAIT or FREEZE is legal (request withdrawn):
  - Next cycle: IDLE, freeze=0.
- Back-to-back auxiliary requests: after a handshake, the next request starts a fresh wait count from 0.
- Reset mid-FREEZE: freeze=0 the cycle after rst is sampled. A pending auxiliary request restarts counting from 0.

## Test plan
- Pipeline only, r3=0x0000_00AA -> rf_wr_en=1, dest=3, value=0xAA; aux_ready=0; freeze stays 0.
- Auxiliary write r5=0x1234_5678 with pipe_wb_en=0 -> written the same cycle; aux_ready=1; aux_squashed=0.
- MAX_WAIT=3, auxiliary r7 blocked by pipeline writes to r1, r2, r4 in cycles 0-2 -> freeze=1 in cycle 3; pipe bubble in cycle 4 writes r7; freeze=0 in cycle 5.
- Auxiliary r9=0x11 waiting while the pipeline writes r9=0x22 -> rf writes 0x22; aux_ready=1; aux_squashed=1; r9 never receives 0x11.
- FREEZE state, aux_valid withdrawn -> next cycle IDLE, freeze=0, no auxiliary write.
- rst asserted during FREEZE with aux_valid held -> freeze=0 after the reset edge; rf_wr_en=0 while rst=1; re-freeze exactly MAX_WAIT blocked cycles after rst deasserts.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: pipeline writeback vs. late auxiliary results
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic [3:0]  pipe_wb_dest,
    input  logic [31:0] pipe_wb_value,
    input  logic        aux_valid,
    input  logic [3:0]  aux_dest,
    input  logic [31:0] aux_value,
    output logic        aux_ready,
    output logic        rf_wr_en,
    output logic [3:0]  rf_wr_dest,
    output logic [31:0] rf_wr_value,
    output logic        freeze,
    output logic        aux_squashed
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       same_dest;
    logic       blocked;
    logic       at_limit;

    always_comb begin
        same_dest    = (pipe_wb_dest == aux_dest);
        aux_ready    = 1'b0;
        aux_squashed = 1'b0;
        rf_wr_en     = 1'b0;
        rf_wr_dest   = 4'd0;
        rf_wr_value  = 32'd0;
        if (!rst) begin
            aux_ready    = aux_valid && (!pipe_wb_en || same_dest);
            aux_squashed = aux_valid && pipe_wb_en && same_dest;
            if (pipe_wb_en) begin
                rf_wr_en    = 1'b1;
                rf_wr_dest  = pipe_wb_dest;
                rf_wr_value = pipe_wb_value;
            end else if (aux_valid) begin
                rf_wr_en    = 1'b1;
                rf_wr_dest  = aux_dest;
                rf_wr_value = aux_value;
            end
        end
    end

    // Blocked means the request loses to a pipeline write to a different register.
    assign blocked  = aux_valid && pipe_wb_en && !same_dest;
    assign at_limit = ({1'b0, wait_cnt_q} + 5'd1) == 5'(MAX_WAIT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 4'd0;
        if (blocked) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (blocked) begin
                    state_d = at_limit ? S_FREEZE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!blocked) begin
                    state_d = S_IDLE;
                end else if (at_limit) begin
                    state_d = S_FREEZE;
                end
            end
            S_FREEZE: begin
                // An in-flight pipeline write may still win here; hold until served or withdrawn.
                if (!blocked) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign freeze = (state_q == S_FREEZE);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wb_en;
    logic [3:0]  pipe_wb_dest;
    logic [31:0] pipe_wb_value;
    logic        aux_valid;
    logic [3:0]  aux_dest;
    logic [31:0] aux_value;
    logic        aux_ready;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_dest;
    logic [31:0] rf_wr_value;
    logic        freeze;
    logic        aux_squashed;

    int n_checks = 0;
    int n_pass   = 0;

    wb_port_arbiter #(.MAX_WAIT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wb_en    (pipe_wb_en),
        .pipe_wb_dest  (pipe_wb_dest),
        .pipe_wb_value (pipe_wb_value),
        .aux_valid     (aux_valid),
        .aux_dest      (aux_dest),
        .aux_value     (aux_value),
        .aux_ready     (aux_ready),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_dest    (rf_wr_dest),
        .rf_wr_value   (rf_wr_value),
        .freeze        (freeze),
        .aux_squashed  (aux_squashed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic pen, input logic [3:0] pd, input logic [31:0] pv,
                         input logic av, input logic [3:0] ad, input logic [31:0] avl);
        pipe_wb_en    = pen;
        pipe_wb_dest  = pd;
        pipe_wb_value = pv;
        aux_valid     = av;
        aux_dest      = ad;
        aux_value     = avl;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic en, input logic [3:0] d, input logic [31:0] v);
        check({tag, ".en"},    32'(rf_wr_en),    32'(en));
        check({tag, ".dest"},  32'(rf_wr_dest),  32'(d));
        check({tag, ".value"}, rf_wr_value,      v);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        next_cycle();
        next_cycle();

        // Reset: outputs forced low even with live requests
        drive(1'b1, 4'd3, 32'hAA, 1'b1, 4'd3, 32'h55);
        check("rst.freeze",   32'(freeze),       32'd0);
        check("rst.rf_en",    32'(rf_wr_en),     32'd0);
        check("rst.ready",    32'(aux_ready),    32'd0);
        check("rst.squashed", 32'(aux_squashed), 32'd0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check_rf("idle", 1'b0, 4'd0, 32'd0);
        next_cycle();

        // Pipeline-only write
        drive(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0);
        check_rf("pipe", 1'b1, 4'd3, 32'hAA);
        check("pipe.ready",  32'(aux_ready), 32'd0);
        check("pipe.freeze", 32'(freeze),    32'd0);
        next_cycle();

        // Auxiliary write with idle pipeline
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h1234_5678);
        check_rf("aux", 1'b1, 4'd5, 32'h1234_5678);
        check("aux.ready",    32'(aux_ready),    32'd1);
        check("aux.squashed", 32'(aux_squashed), 32'd0);
        next_cycle();

        // Starvation: r7 blocked by r1, r2, r4 then freeze
        drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd7, 32'h77);
        check_rf("blk0", 1'b1, 4'd1, 32'hA1);
        check("blk0.ready",  32'(aux_ready), 32'd0);
        check("blk0.freeze", 32'(freeze),    32'd0);
        next_cycle();
        drive(1'b1, 4'd2, 32'hA2, 1'b1, 4'd7, 32'h77);
        check("blk1.freeze", 32'(freeze), 32'd0);
        next_cycle();
        drive(1'b1, 4'd4, 32'hA4, 1'b1, 4'd7, 32'h77);
        check("blk2.freeze", 32'(freeze), 32'd0);
        next_cycle();
        // In-flight pipeline write during the first freeze cycle still wins
        drive(1'b1, 4'd6, 32'hA6, 1'b1, 4'd7, 32'h77);
        check("blk3.freeze", 32'(freeze), 32'd1);
        check_rf("blk3", 1'b1, 4'd6, 32'hA6);
        check("blk3.ready",  32'(aux_ready), 32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h77);
        check("bub.freeze", 32'(freeze), 32'd1);
        check_rf("bub", 1'b1, 4'd7, 32'h77);
        check("bub.ready",  32'(aux_ready), 32'd1);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check("post.freeze", 32'(freeze), 32'd0);
        check_rf("post", 1'b0, 4'd0, 32'd0);
        next_cycle();

        // Squash: r9=0x11 superseded by pipeline r9=0x22
        drive(1'b1, 4'd2, 32'h33, 1'b1, 4'd9, 32'h11);
        check("sq0.ready", 32'(aux_ready), 32'd0);
        next_cycle();
        drive(1'b1, 4'd9, 32'h22, 1'b1, 4'd9, 32'h11);
        check_rf("sq1", 1'b1, 4'd9, 32'h22);
        check("sq1.ready",    32'(aux_ready),    32'd1);
        check("sq1.squashed", 32'(aux_squashed), 32'd1);
        check("sq1.freeze",   32'(freeze),       32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check("sq2.rf_en", 32'(rf_wr_en), 32'd0);
        next_cycle();

        // Withdrawal while frozen
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd1, 32'hB0, 1'b1, 4'd8, 32'h88);
            check("wd.pre_freeze", 32'(freeze), 32'd0);
            next_cycle();
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check("wd.freeze",    32'(freeze),   32'd1);
        check("wd.rf_en",     32'(rf_wr_en), 32'd0);
        next_cycle();
        drive(1'b1, 4'd1, 32'hB1, 1'b1, 4'd8, 32'h88);
        check("wd.after",     32'(freeze),   32'd0);
        next_cycle();
        drive(1'b1, 4'd1, 32'hB2, 1'b1, 4'd8, 32'h88);
        check("wd.recount",   32'(freeze),   32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        next_cycle();

        // Reset during freeze with aux_valid held
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd2, 32'hC0, 1'b1, 4'd10, 32'hAA10);
            next_cycle();
        end
        rst = 1'b1;
        drive(1'b1, 4'd2, 32'hC0, 1'b1, 4'd10, 32'hAA10);
        check("rf.freeze_in_rst", 32'(freeze),   32'd1);
        check("rf.rf_en_in_rst",  32'(rf_wr_en), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd2, 32'hC1, 1'b1, 4'd10, 32'hAA10);
            check($sformatf("rf.c%0d.freeze", i), 32'(freeze), 32'd0);
            next_cycle();
        end
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd10, 32'hAA10);
        check("rf.c3.freeze", 32'(freeze), 32'd1);
        check_rf("rf.c3", 1'b1, 4'd10, 32'hAA10);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check("rf.c4.freeze", 32'(freeze), 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
